// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way cache controller.
// Combinational helpers only; no latency or backpressure of their own.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cacheState_t;

  function automatic int offW(input int words);
    return $clog2(words);
  endfunction

  function automatic int idxW(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagW(input int addrW, input int words, input int sets);
    return addrW - 1 - offW(words) - idxW(sets);
  endfunction

  // A direct-mapped build still needs a 1-bit way/age field to index with.
  function automatic int wayW(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] addrField(input logic [31:0] addr, input int lsb,
                                            input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_nway_ctrl_if.sv
// CPU request/response and memory request/return signals of the cache controller.
// slave = cache side, master = CPU plus memory side.
interface cache_nway_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, flush,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, flush,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU ages per set: victim select (lowest invalid, else oldest) and MRU update.
// Victim is combinational on lookIdx; update lands on the next edge; never stalls.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  localparam int WAY_W = wayW(WAYS),
  localparam int IDX_W = idxW(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookIdx,
  input  logic [WAYS-1:0]  validVec,
  output logic [WAY_W-1:0] victimWay,
  input  logic             updEn,
  input  logic [IDX_W-1:0] updIdx,
  input  logic [WAY_W-1:0] updWay
);

  logic [WAY_W-1:0] age [SETS][WAYS];

  // Second loop runs after the first so any invalid way overrides the oldest one.
  always_comb begin
    victimWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age[lookIdx][w] == WAY_W'(WAYS - 1)) victimWay = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validVec[w]) victimWay = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
      end
    end else if (updEn) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == updWay) begin
          age[updIdx][w] <= '0;
        end else if (age[updIdx][w] < age[updIdx][updWay]) begin
          age[updIdx][w] <= age[updIdx][w] + WAY_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way write-through, no-write-allocate cache with in-order miss fill, critical word first.
// Read hit: 1 cycle, back-to-back; miss/write hold req_ready low until fill or mem write completes.
module cache_nway_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_nway_ctrl_if.slave bus
);

  localparam int OFF_W = offW(WORDS);
  localparam int IDX_W = idxW(SETS);
  localparam int TAG_W = tagW(ADDR_W, WORDS, SETS);
  localparam int WAY_W = wayW(WAYS);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  cacheState_t state, nextState;

  logic [TAG_W-1:0]  tagArr  [WAYS][SETS];
  logic [DATA_W-1:0] dataArr [WAYS][SETS][WORDS];
  logic [WAYS-1:0]   validArr [SETS];

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_W-1:0]  reqOff;
  logic              accept, flushNow, hit, fillDone, critical;
  logic [WAYS-1:0]   hitVec;
  logic [WAY_W-1:0]  hitWay, victimWay;

  logic              lruUpdEn;
  logic [IDX_W-1:0]  lruUpdIdx;
  logic [WAY_W-1:0]  lruUpdWay;

  logic              memReq, memWe, respHit;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, respData;
  logic [OFF_W-1:0]  issueCnt, retCnt, fillOff;
  logic [IDX_W-1:0]  fillIdx;
  logic [TAG_W-1:0]  fillTag;
  logic [WAY_W-1:0]  fillWay;

  assign reqTag = TAG_W'(addrField(32'(bus.req_addr), 1 + OFF_W + IDX_W, TAG_W));
  assign reqIdx = IDX_W'(addrField(32'(bus.req_addr), 1 + OFF_W, IDX_W));
  assign reqOff = OFF_W'(addrField(32'(bus.req_addr), 1, OFF_W));

  assign bus.req_ready = (state == IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign flushNow      = (state == IDLE) && bus.flush;

  always_comb begin
    hitVec = '0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      hitVec[w] = validArr[reqIdx][w] && (tagArr[w][reqIdx] == reqTag);
      if (hitVec[w]) hitWay = WAY_W'(w);
    end
    hit = |hitVec;
  end

  assign fillDone = (state == FILL) && bus.mem_rvalid && (retCnt == LAST_WORD);
  assign critical = (state == FILL) && bus.mem_rvalid && (retCnt == fillOff);

  assign lruUpdEn  = (accept && hit) || fillDone;
  assign lruUpdIdx = fillDone ? fillIdx : reqIdx;
  assign lruUpdWay = fillDone ? fillWay : hitWay;

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) uLru (
    .clk       (clk),
    .rst       (rst),
    .lookIdx   (reqIdx),
    .validVec  (validArr[reqIdx]),
    .victimWay (victimWay),
    .updEn     (lruUpdEn),
    .updIdx    (lruUpdIdx),
    .updWay    (lruUpdWay)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_we)  nextState = WRITE;
          else if (!hit)   nextState = FILL;
        end
      end
      FILL:    if (fillDone) nextState = IDLE;
      WRITE:   if (bus.mem_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      respHit  <= 1'b0;
      respData <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
      fillOff  <= '0;
      fillIdx  <= '0;
      fillTag  <= '0;
      fillWay  <= '0;
    end else begin
      state   <= nextState;
      respHit <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.req_we) begin
              memReq   <= 1'b1;
              memWe    <= 1'b1;
              memAddr  <= bus.req_addr;
              memWdata <= bus.req_wdata;
            end else if (hit) begin
              respHit  <= 1'b1;
              respData <= dataArr[hitWay][reqIdx][reqOff];
            end else begin
              memReq   <= 1'b1;
              memWe    <= 1'b0;
              memAddr  <= {reqTag, reqIdx, {(OFF_W + 1){1'b0}}};
              issueCnt <= '0;
              retCnt   <= '0;
              fillOff  <= reqOff;
              fillIdx  <= reqIdx;
              fillTag  <= reqTag;
              fillWay  <= victimWay;
            end
          end
        end
        FILL: begin
          if (memReq && bus.mem_ready) begin
            if (issueCnt == LAST_WORD) begin
              memReq <= 1'b0;
            end else begin
              issueCnt <= issueCnt + OFF_W'(1);
              memAddr  <= memAddr + ADDR_W'(2);
            end
          end
          if (bus.mem_rvalid) retCnt <= retCnt + OFF_W'(1);
        end
        WRITE: begin
          if (bus.mem_ready) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && hit) dataArr[hitWay][reqIdx][reqOff] <= bus.req_wdata;
    if ((state == FILL) && bus.mem_rvalid) dataArr[fillWay][fillIdx][retCnt] <= bus.mem_rdata;
    if (fillDone) tagArr[fillWay][fillIdx] <= fillTag;
  end

  // Victim is invalidated at miss acceptance so a partially refilled line can never hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) validArr[s] <= '0;
    end else if (flushNow) begin
      for (int s = 0; s < SETS; s++) validArr[s] <= '0;
    end else if (accept && !bus.req_we && !hit) begin
      validArr[reqIdx][victimWay] <= 1'b0;
    end else if (fillDone) begin
      validArr[fillIdx][fillWay] <= 1'b1;
    end
  end

  assign bus.resp_valid = respHit || critical || ((state == WRITE) && bus.mem_ready);
  assign bus.resp_rdata = critical ? bus.mem_rdata : respData;
  assign bus.mem_req    = memReq;
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: scoreboard queues for CPU responses and memory requests.
// Memory model returns reads in order two cycles after acceptance and stalls every fifth cycle.
module tb_cache_nway_ctrl;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } memOp_t;

  typedef struct {
    logic        chk;
    logic [15:0] data;
    longint      due;
  } respExp_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } memRet_t;

  logic clk;
  logic rst;

  cache_nway_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_nway_ctrl #(
    .ADDR_W (16),
    .DATA_W (16),
    .WAYS   (2),
    .SETS   (64),
    .WORDS  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCmp  = 0;
  int nFail = 0;
  int memCyc = 0;
  int rvCnt  = 0;

  memOp_t   expMem [$];
  respExp_t expQ   [$];
  memRet_t  pipeQ  [$];
  logic [15:0] memArr [32768];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: word at byte address a holds 0x1000 + a/2, except block 0x0040 holds 0xA000 + i.
  initial begin
    memRet_t rd;
    for (int i = 0; i < 32768; i++) memArr[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 8; i++) memArr[16'h20 + i] = 16'hA000 + 16'(i);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      memCyc++;
      bus.mem_rvalid = 1'b0;
      if (!rst) begin
        pipeQ.delete();
        bus.mem_ready = 1'b1;
      end else begin
        if (pipeQ.size() > 0 && pipeQ[0].due <= memCyc) begin
          rd = pipeQ.pop_front();
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd.data;
          rvCnt++;
        end
        bus.mem_ready = (memCyc % 5) != 3;
        if (bus.mem_req && bus.mem_ready) begin
          if (bus.mem_we) memArr[bus.mem_addr[15:1]] = bus.mem_wdata;
          else pipeQ.push_back('{data: memArr[bus.mem_addr[15:1]], due: memCyc + 2});
        end
      end
    end
  end

  // Monitor: samples mid-cycle, pops responses and memory handshakes against the queues.
  initial begin
    respExp_t e;
    memOp_t   m;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (bus.resp_valid) begin
          if (expQ.size() == 0) begin
            nCmp++;
            nFail++;
            $display("FAIL resp_unexpected: got data 0x%0h at %0t, want no response", bus.resp_rdata, $time);
          end else begin
            e = expQ.pop_front();
            if (e.chk) check("resp_rdata", 32'(bus.resp_rdata), 32'(e.data));
            if (e.due != 0) check("resp_latency", 32'($time), 32'(e.due));
          end
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (expMem.size() == 0) begin
            nCmp++;
            nFail++;
            $display("FAIL mem_unexpected: got we %0b addr 0x%0h, want no request", bus.mem_we, bus.mem_addr);
          end else begin
            m = expMem.pop_front();
            check("mem_we", 32'(bus.mem_we), 32'(m.we));
            check("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
            if (m.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m.data));
          end
        end
      end
    end
  end

  task automatic doReq(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       output longint acc);
    int n = 0;
    @(negedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) check("req_accept_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    acc = $time;
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic pushFill(input logic [15:0] addr);
    for (int i = 0; i < 8; i++)
      expMem.push_back('{we: 1'b0, addr: {addr[15:4], 4'h0} + 16'(2 * i), data: 16'h0});
  endtask

  task automatic rdMiss(input logic [15:0] addr, input logic [15:0] expData);
    longint t;
    pushFill(addr);
    doReq(1'b0, addr, 16'h0, t);
    expQ.push_back('{chk: 1'b1, data: expData, due: 0});
  endtask

  task automatic rdHit(input logic [15:0] addr, input logic [15:0] expData);
    longint t;
    doReq(1'b0, addr, 16'h0, t);
    expQ.push_back('{chk: 1'b1, data: expData, due: t + 7});
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    longint t;
    expMem.push_back('{we: 1'b1, addr: addr, data: data});
    doReq(1'b1, addr, data, t);
    expQ.push_back('{chk: 1'b0, data: 16'h0, due: 0});
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    #1;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) check("idle_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    longint t;
    int     rv0;
    int     n;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.flush     = 1'b0;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Cold miss, then a 1-cycle hit in the same block.
    rdMiss(16'h0000, 16'h1000);
    rdHit(16'h0002, 16'h1001);

    // Critical word at offset 3; ready must stay low until all 8 returns.
    waitIdle();
    rv0 = rvCnt;
    rdMiss(16'h0046, 16'hA003);
    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ready_after_8_returns", 32'(rvCnt - rv0), 32'd8);

    // LRU in set 0.
    rdMiss(16'h0400, 16'h1200);
    rdHit(16'h0000, 16'h1000);
    rdMiss(16'h0800, 16'h1400);
    rdHit(16'h0000, 16'h1000);
    rdMiss(16'h0400, 16'h1200);

    // Write-through hit, then write miss with no allocation.
    wr(16'h0004, 16'hBEEF);
    rdHit(16'h0004, 16'hBEEF);
    wr(16'h1004, 16'h5A5A);
    rdMiss(16'h1004, 16'h5A5A);

    // Flush beats a concurrent request.
    waitIdle();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    #1;
    check("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    rdMiss(16'h0000, 16'h1000);
    rdHit(16'h0004, 16'hBEEF);

    // Reset after 3 fill returns discards the partial line.
    waitIdle();
    pushFill(16'h020E);
    doReq(1'b0, 16'h020E, 16'h0, t);
    rv0 = rvCnt;
    n = 0;
    while ((rvCnt - rv0) < 3 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_3_returns", 32'(rvCnt - rv0), 32'd3);
    rst = 1'b0;
    expMem.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    rdMiss(16'h0000, 16'h1000);
    rdMiss(16'h020E, 16'h1107);

    n = 0;
    while ((expQ.size() + expMem.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("drain_outstanding", 32'(expQ.size() + expMem.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_nway_ctrl.md
Name: cache_nway_ctrl

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate cache with its own miss-fill engine.
- Successor to the fixed 2-way data/meta cache: adds configurable ways, sets and block size, valid bits, true-LRU replacement, flush, and critical-word-first response.
- Sits between the pipeline memory stage (CPU side) and main memory, which is pipelined and returns reads in order.

Parameters:
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width; word aligned, addr bit 0 ignored.
- WAYS, 2: associativity; power of 2, 1..8.
- SETS, 64: sets; power of 2.
- WORDS, 8: words per block; power of 2.
- Derived, not overridable: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-1-OFF_W-IDX_W.
- Address fields: tag [ADDR_W-1:1+OFF_W+IDX_W], index [OFF_W+IDX_W:1+OFF_W], word offset [OFF_W:1].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  CPU request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  request accepted when req_valid & req_ready.
- resp_valid  out  1  one-cycle pulse: read data valid, or write done.
- resp_rdata  out  DATA_W  read data.
- flush  in  1  invalidate all lines.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data return, in request order.
- mem_rdata  in  DATA_W  read return data.

Behaviour:
- Reset (async, rst=0):
  - State IDLE; all valid bits 0; LRU ages of way w = w.
  - resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data and tag arrays are not reset.
- req_ready = (state==IDLE) & ~flush.
- Flush: in IDLE it has priority; one cycle, clears all valid bits; no request accepted that cycle. Ignored outside IDLE.
- States: IDLE, FILL, WRITE.
- Lookup: on acceptance, the indexed set is compared across all ways; hit = valid & tag match; at most one way matches.
- Read hit:
  - resp_valid=1 with the word on the next cycle.
  - Hit way becomes MRU; state stays IDLE, so back-to-back hits run at 1/cycle.
- Read miss, IDLE->FILL:
  - Victim = lowest-index invalid way, else way with age WAYS-1.
  - Issue WORDS reads, addresses block_base + 2*i for i=0..WORDS-1. One is issued per cycle while mem_ready=1; the issue counter advances only on mem_ready.
  - Each mem_rvalid writes word (return counter) into the victim way.
  - Critical word: when the return counter equals the requested offset, resp_valid=1 that cycle and resp_rdata=mem_rdata (combinational bypass).
  - On the WORDS-th return: tag written, valid set, victim becomes MRU, then IDLE.
  - The line is never valid mid-fill, so a partial fill cannot hit.
- Write, IDLE->WRITE:
  - On hit, the word is updated in the hit way and that way becomes MRU.
  - On miss, the cache is unchanged.
  - Drive mem_req=1, mem_we=1, mem_addr, mem_wdata until mem_ready; that cycle resp_valid=1, then IDLE.
- LRU update on the accessed way a (per set, log2(WAYS)-bit ages): ways with age < age[a] increment, then age[a]=0. Ages stay a permutation of 0..WAYS-1.
- mem_req is registered output in FILL/WRITE; mem_rvalid outside FILL is ignored.
- Reset mid-FILL or mid-WRITE: returns to IDLE immediately, the partial line is discarded (invalid), and memory is reset on the same rst.

Decomposition:
- Package cache_pkg holds: state enum (IDLE, FILL, WRITE), clog2-based derived-width functions, and an address-field extraction function.
- Sub-module cache_lru: per-set age storage, victim select, MRU update; parametrised by WAYS and SETS.
- Data, tag and valid arrays stay in the top.

Test Plan:
- Defaults; reset; read 0x0000 -> 8 mem reads 0x0000..0x000E; resp_valid with word 0; then read 0x0002 -> hit 1 cycle later, mem_req stays 0.
- Read 0x0046 miss, memory returns words as 0xA000+i -> resp_rdata=0xA003 on the 4th return; req_ready stays 0 until after the 8th return.
- LRU, set 0:
  - Read 0x0000 (way0), then 0x0400 (way1), then 0x0000 (hit).
  - Read 0x0800 -> evicts the 0x0400 line.
  - Read 0x0000 -> hit; read 0x0400 -> miss.
- Write 0x0004=0xBEEF after 0x0000 filled -> mem write addr 0x0004 data 0xBEEF; read 0x0004 -> 0xBEEF with no mem read. Write 0x1004 (miss) -> mem write only; read 0x1004 -> miss.
- Flush concurrent with req_valid -> req_ready=0 that cycle; read 0x0000 afterwards misses.
- rst=0 after 3 fill returns, then release -> mem_req=0, req_ready=1; read 0x0000 misses and issues all 8 reads again.
